// File: rtl/vc_vr_out_stage.sv
// rtl/vc_vr_out_stage.sv - valid/credit to valid/ready converter output stage
//
// Drains the converter FIFO into a registered valid/ready output and returns
// one credit upstream per popped word. After reset, the INIT state hands out
// DEPTH initial credits, one per cycle, before any word is popped.
//
// Optional feature macro: VC_VR_CREDIT_CHK_EN (adds an upstream credit checker)
//
// Ports:
//   clk_i         in   clock, rising edge
//   rst_i         in   synchronous reset, active-high
//   fifo_data_i   in   FIFO head word, valid while fifo_empty_i=0
//   fifo_empty_i  in   FIFO empty flag
//   fifo_pop_o    out  FIFO pop strobe (combinational)
//   up_credit_o   out  one-cycle credit pulse to upstream (registered)
//   dn_valid_o    out  downstream valid (registered)
//   dn_data_o     out  downstream data (registered)
//   dn_ready_i    in   downstream ready
//   up_valid_i    in   upstream push strobe, monitor only (VC_VR_CREDIT_CHK_EN)
//   credit_err_o  out  sticky credit protocol error (VC_VR_CREDIT_CHK_EN)

module vc_vr_out_stage #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 10
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] fifo_data_i,
   input  logic             fifo_empty_i,
   output logic             fifo_pop_o,
   output logic             up_credit_o,
   output logic             dn_valid_o,
   output logic [WIDTH-1:0] dn_data_o,
   input  logic             dn_ready_i
`ifdef VC_VR_CREDIT_CHK_EN
   ,
   input  logic             up_valid_i,
   output logic             credit_err_o
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] LAST_INIT = CW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] init_cnt_q;
   logic [CW-1:0] init_cnt_d;
   logic          credit_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      fifo_pop_o = 1'b0;
      credit_d   = 1'b0;
      case (state_q)
         S_INIT: begin
            // One initial credit per INIT cycle; no pops until RUN.
            credit_d   = 1'b1;
            init_cnt_d = init_cnt_q + CW'(1);
            if (init_cnt_q == LAST_INIT) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Pop whenever the output register is free or being drained now.
            fifo_pop_o = ~fifo_empty_i & (~dn_valid_o | dn_ready_i);
            credit_d   = fifo_pop_o;
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   // Credit pulse is one register after the pop, so each popped word yields
   // its own distinct pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         up_credit_o <= 1'b0;
      end else begin
         up_credit_o <= credit_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dn_valid_o <= 1'b0;
         dn_data_o  <= '0;
      end else if (fifo_pop_o) begin
         dn_valid_o <= 1'b1;
         dn_data_o  <= fifo_data_i;
      end else if (dn_valid_o && dn_ready_i) begin
         dn_valid_o <= 1'b0;
      end
   end

`ifdef VC_VR_CREDIT_CHK_EN
   logic [CW-1:0] credit_avail_q;

   // Tracks credits held by upstream; flags pushes without credit and credit
   // returns beyond DEPTH. The counter never wraps in either direction.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         credit_avail_q <= '0;
         credit_err_o   <= 1'b0;
      end else begin
         case ({up_credit_o, up_valid_i})
            2'b10: begin
               if (credit_avail_q == DEPTH_C) begin
                  credit_err_o <= 1'b1;
               end else begin
                  credit_avail_q <= credit_avail_q + CW'(1);
               end
            end
            2'b01: begin
               if (credit_avail_q == '0) begin
                  credit_err_o <= 1'b1;
               end else begin
                  credit_avail_q <= credit_avail_q - CW'(1);
               end
            end
            default: begin
               credit_avail_q <= credit_avail_q;
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_vc_vr_out_stage.sv
// tb/tb_vc_vr_out_stage.sv - scoreboard testbench for vc_vr_out_stage

module tb_vc_vr_out_stage;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [7:0] fifo_data_i;
   logic       fifo_empty_i;
   logic       fifo_pop_o;
   logic       up_credit_o;
   logic       dn_valid_o;
   logic [7:0] dn_data_o;
   logic       dn_ready_i;
`ifdef VC_VR_CREDIT_CHK_EN
   logic       up_valid_i;
   logic       credit_err_o;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] mem [0:31];
   logic [4:0] wr_ptr = '0;
   logic [4:0] rd_ptr = '0;
   logic [7:0] exp_q [$];
   logic       chk_credit = 1'b0;
   logic       pop_prev = 1'b0;

   always #5 clk_i = ~clk_i;

   vc_vr_out_stage #(.WIDTH(8), .DEPTH(10)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_pop_o   (fifo_pop_o),
      .up_credit_o  (up_credit_o),
      .dn_valid_o   (dn_valid_o),
      .dn_data_o    (dn_data_o),
      .dn_ready_i   (dn_ready_i)
`ifdef VC_VR_CREDIT_CHK_EN
      ,
      .up_valid_i   (up_valid_i),
      .credit_err_o (credit_err_o)
`endif
   );

   // FIFO model shared with the DUT: reset on the same rst_i.
   assign fifo_empty_i = (rd_ptr == wr_ptr);
   assign fifo_data_i  = mem[rd_ptr];

   always @(posedge clk_i) begin
      if (rst_i) rd_ptr <= wr_ptr;
      else if (fifo_pop_o) rd_ptr <= rd_ptr + 5'd1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input bit expect_out);
      mem[wr_ptr] = d;
      wr_ptr = wr_ptr + 5'd1;
      if (expect_out) exp_q.push_back(d);
   endtask

   // Monitor: data transfers against the scoreboard, credits against pops.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (dn_valid_o && dn_ready_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_transfer", {24'd0, dn_data_o}, 32'hFFFF_FFFF);
            end else begin
               check("dn_data", {24'd0, dn_data_o}, {24'd0, exp_q.pop_front()});
            end
         end
         if (chk_credit) check("credit_after_pop", {31'd0, up_credit_o}, {31'd0, pop_prev});
      end
      pop_prev = fifo_pop_o;
   end

   initial begin
      rst_i = 1'b1;
      dn_ready_i = 1'b0;
`ifdef VC_VR_CREDIT_CHK_EN
      up_valid_i = 1'b0;
`endif
      repeat (3) step();
      check("rst_dn_valid", {31'd0, dn_valid_o}, 32'd0);
      check("rst_dn_data", {24'd0, dn_data_o}, 32'd0);
      check("rst_up_credit", {31'd0, up_credit_o}, 32'd0);
`ifdef VC_VR_CREDIT_CHK_EN
      check("rst_credit_err", {31'd0, credit_err_o}, 32'd0);
`endif

      // INIT: exactly 10 credit pulses, no pops, no output.
      rst_i = 1'b0;
      for (int i = 0; i < 14; i++) begin
         step();
         check("init_credit", {31'd0, up_credit_o}, (i < 10) ? 32'd1 : 32'd0);
         check("init_dn_valid", {31'd0, dn_valid_o}, 32'd0);
         check("init_pop", {31'd0, fifo_pop_o}, 32'd0);
      end
      chk_credit = 1'b1;

      // Streaming three words with ready held high.
      dn_ready_i = 1'b1;
      push(8'h11, 1'b1);
      push(8'h22, 1'b1);
      push(8'h33, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stream_valid", {31'd0, dn_valid_o}, 32'd1);
      end
      step();
      check("stream_drain_valid", {31'd0, dn_valid_o}, 32'd0);

      // Backpressure with 0xA5 held in the output register.
      dn_ready_i = 1'b0;
      push(8'hA5, 1'b1);
      push(8'hB6, 1'b1);
      step();
      check("bp_first", {24'd0, dn_data_o}, 32'hA5);
      for (int i = 0; i < 4; i++) begin
         step();
         check("bp_data", {24'd0, dn_data_o}, 32'hA5);
         check("bp_valid", {31'd0, dn_valid_o}, 32'd1);
         check("bp_pop", {31'd0, fifo_pop_o}, 32'd0);
         check("bp_credit", {31'd0, up_credit_o}, 32'd0);
      end
      dn_ready_i = 1'b1;
      step();
      check("bp_next_data", {24'd0, dn_data_o}, 32'hB6);
      check("bp_next_valid", {31'd0, dn_valid_o}, 32'd1);
      step();
      check("empty_valid_drop", {31'd0, dn_valid_o}, 32'd0);

      // Push into an empty FIFO: valid one cycle after empty falls.
      step();
      push(8'h5C, 1'b1);
      step();
      check("push_5c_valid", {31'd0, dn_valid_o}, 32'd1);
      check("push_5c_data", {24'd0, dn_data_o}, 32'h5C);
      step();
      check("push_5c_drain", {31'd0, dn_valid_o}, 32'd0);
      check("scoreboard_empty", exp_q.size(), 32'd0);

      // Reset while the output register holds a word.
      dn_ready_i = 1'b0;
      push(8'h77, 1'b0);
      step();
      check("pre_rst_valid", {31'd0, dn_valid_o}, 32'd1);
      chk_credit = 1'b0;
      rst_i = 1'b1;
      step();
      check("midrst_valid", {31'd0, dn_valid_o}, 32'd0);
      check("midrst_data", {24'd0, dn_data_o}, 32'd0);
      rst_i = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         check("reinit_credit", {31'd0, up_credit_o}, (i < 10) ? 32'd1 : 32'd0);
         check("reinit_valid", {31'd0, dn_valid_o}, 32'd0);
      end
      chk_credit = 1'b1;

`ifdef VC_VR_CREDIT_CHK_EN
      // Ten credits held upstream; the eleventh push has none.
      check("chk_err_clear", {31'd0, credit_err_o}, 32'd0);
      for (int k = 1; k <= 11; k++) begin
         up_valid_i = 1'b1;
         step();
         check("chk_err_push", {31'd0, credit_err_o}, (k == 11) ? 32'd1 : 32'd0);
      end
      up_valid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("chk_err_sticky", {31'd0, credit_err_o}, 32'd1);
      end
`endif

      check("scoreboard_final", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
